mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have these ports: clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have these ports: rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have these ports: stall, input, `StallBus (6), pipeline stall vector; bit 3 = this stage, bit 4 = WB.
REQ-005 The block SHALL have these ports: ex_to_mem_bus, input, 212, EX result bundle, MSB first:
- inst_h, inst_hu, inst_b, inst_bu
- hi_we, hi_wdata[32], lo_we, lo_wdata[32]
- r_lo, r_lo_data[32], r_hi, r_hi_data[32]
- pc[32], data_ram_en, data_ram_wen[4], sel_rf_res, rf_we, rf_waddr[5], ex_result[32]
REQ-006 The block SHALL have these ports: data_sram_rdata, input, 32, data SRAM read word; valid only in the cycle after EX presented the address.
REQ-007 The block SHALL have these ports: mem_to_wb_bus, output, 136, MSB first: hi_we, hi_wdata, lo_we, lo_wdata, pc, rf_we, rf_waddr, rf_wdata.
REQ-008 The block SHALL have these ports: mem_to_id_bus, output, 104, forwarding bundle, MSB first: hi_we, hi_wdata, lo_we, lo_wdata, rf_we, rf_waddr, rf_wdata.

Function
REQ-009 The stage register SHALL update on each clock edge as follows:
- stall[3]=Stop and stall[4]=NoStop: load all-zero (bubble).
- Otherwise stall[3]=NoStop: load ex_to_mem_bus.
- Otherwise: hold.
REQ-010 A bubble SHALL produce rf_we=0, hi_we=0, lo_we=0 on both output buses.
REQ-011 A registered instruction SHALL be a load when data_ram_en=1 and data_ram_wen=4'b0000.
REQ-012 The load-data FSM SHALL have states IDLE, FRESH and HELD; its state SHALL change only on the edges where the stage register changes:
- On a register update: FRESH if the new contents are a load, otherwise IDLE.
- On a hold edge: FRESH SHALL go to HELD; IDLE and HELD SHALL stay.
REQ-013 A 32-bit hold register SHALL capture data_sram_rdata on every FRESH-to-HELD edge and SHALL be unchanged otherwise.
REQ-014 The raw load word SHALL be data_sram_rdata in FRESH and the hold register in HELD.
REQ-015 Load alignment SHALL use a = ex_result[1:0]:
- inst_b / inst_bu: byte a, sign- / zero-extended.
- inst_h / inst_hu: halfword a[1], sign- / zero-extended; a[0] ignored.
- None of the four flags set: full word.
REQ-016 rf_wdata SHALL be selected with this priority:
- sel_rf_res=1: aligned load data.
- else r_hi=1: r_hi_data.
- else r_lo=1: r_lo_data.
- else: ex_result.
REQ-017 The hi_we, hi_wdata, lo_we, lo_wdata, pc, rf_we and rf_waddr fields SHALL pass through unchanged from the stage register.
REQ-018 mem_to_id_bus SHALL carry the same field values as mem_to_wb_bus in the same cycle, with zero added latency.
REQ-019 Latency SHALL be one cycle from EX output to mem_to_wb_bus when not stalled.
REQ-020 Store instructions SHALL never drive rf_we=1 unless the upstream bundle set it.

Reset
REQ-021 While rst=0, the stage register SHALL be zero, the FSM SHALL be IDLE and the hold register SHALL be zero, asynchronously.
REQ-022 With rst=0, all outputs SHALL read zero.
REQ-023 Reset asserted in FRESH or HELD SHALL discard the pending load; after release the first update SHALL be a normal register load.

Structure
REQ-024 Bus widths (MEM_TO_WB_WD=136, MEM_TO_ID_WD=104, EX_TO_MEM_WD=212), `Stop/`NoStop, `StallBus and FSM state encodings SHALL live in the shared defines file.
REQ-025 Byte/halfword extraction SHALL be a combinational sub-module named load_align (inputs: word, addr[1:0], b, bu, h, hu; output: 32-bit data).

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- lb with ex_result=0x1003, rdata=0x80FF_1234, no stall -> rf_wdata=0xFFFF_FF80, rf_we=1 one cycle later.
- lhu with ex_result=0x2002, rdata=0xBEEF_0001 -> rf_wdata=0x0000_BEEF; same with lh -> 0xFFFF_BEEF.
- lw, rdata=0x1122_3344 in FRESH, stall[3]=stall[4]=Stop for 3 cycles while rdata changes to 0xDEAD_BEEF -> rf_wdata stays 0x1122_3344 throughout and after release.
- stall[3]=Stop, stall[4]=NoStop -> next cycle rf_we=hi_we=lo_we=0 and pc=0 (bubble).
- mfhi bundle (r_hi=1, r_hi_data=0xCAFE_0001, sel_rf_res=0) -> rf_wdata=0xCAFE_0001 on both buses the same cycle.
- rst asserted mid-HELD -> outputs zero immediately; after release a new lw returns its own fresh rdata, not the held word.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, stall encodings,
// load-FSM states and the EX->MEM bundle layout.
package mem_stage_pkg;

  localparam int DATA_W       = 32;
  localparam int EX_TO_MEM_WD = 212;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_ID_WD = 104;
  localparam int STALL_BUS_WD = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_FRESH = 2'd1,
    LD_HELD  = 2'd2
  } ld_state_e;

  typedef struct packed {
    logic              inst_h;
    logic              inst_hu;
    logic              inst_b;
    logic              inst_bu;
    logic              hi_we;
    logic [DATA_W-1:0] hi_wdata;
    logic              lo_we;
    logic [DATA_W-1:0] lo_wdata;
    logic              r_lo;
    logic [DATA_W-1:0] r_lo_data;
    logic              r_hi;
    logic [DATA_W-1:0] r_hi_data;
    logic [DATA_W-1:0] pc;
    logic              data_ram_en;
    logic [3:0]        data_ram_wen;
    logic              sel_rf_res;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] ex_result;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t e);
    return e.data_ram_en && (e.data_ram_wen == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the MEM stage data buses; master drives stimulus, slave is the stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [STALL_BUS_WD-1:0] stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [DATA_W-1:0]       data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

  modport master (
    output stall, ex_to_mem_bus, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_bus
  );

  modport slave (
    input  stall, ex_to_mem_bus, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_bus
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Byte/halfword extraction and extension of a raw load word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr,
  input  logic              b,
  input  logic              bu,
  input  logic              h,
  input  logic              hu,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];

    data = word;
    if (b)       data = {{24{byte_sel[7]}}, byte_sel};
    else if (bu) data = {24'd0, byte_sel};
    else if (h)  data = {{16{half_sel[15]}}, half_sel};
    else if (hu) data = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: stage register, load-data FSM with a hold register so a
// load survives stalls after the one-cycle SRAM read data has gone away.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  ex_to_mem_t        stage_q, stage_d;
  ld_state_e         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] raw_word;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] rf_wdata;
  logic              bubble;
  logic              update;

  // Stage register: bubble when this stage stops but WB moves on.
  always_comb begin
    bubble  = (bus.stall[STALL_MEM] == STOP) && (bus.stall[STALL_WB] == NO_STOP);
    update  = bubble || (bus.stall[STALL_MEM] == NO_STOP);
    stage_d = stage_q;
    if (bubble)
      stage_d = '0;
    else if (bus.stall[STALL_MEM] == NO_STOP)
      stage_d = ex_to_mem_t'(bus.ex_to_mem_bus);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
      state_q <= LD_IDLE;
      hold_q  <= '0;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Load FSM next state: only moves with the stage register, except FRESH->HELD.
  always_comb begin
    state_d = state_q;
    if (update)
      state_d = is_load(stage_d) ? LD_FRESH : LD_IDLE;
    else if (state_q == LD_FRESH)
      state_d = LD_HELD;
  end

  always_comb begin
    hold_d   = hold_q;
    raw_word = '0;
    case (state_q)
      LD_FRESH: begin
        raw_word = bus.data_sram_rdata;
        if (state_d == LD_HELD)
          hold_d = bus.data_sram_rdata;
      end
      LD_HELD:  raw_word = hold_q;
      default:  raw_word = '0;
    endcase
  end

  load_align u_load_align (
    .word (raw_word),
    .addr (stage_q.ex_result[1:0]),
    .b    (stage_q.inst_b),
    .bu   (stage_q.inst_bu),
    .h    (stage_q.inst_h),
    .hu   (stage_q.inst_hu),
    .data (aligned)
  );

  always_comb begin
    if (stage_q.sel_rf_res)
      rf_wdata = aligned;
    else if (stage_q.r_hi)
      rf_wdata = stage_q.r_hi_data;
    else if (stage_q.r_lo)
      rf_wdata = stage_q.r_lo_data;
    else
      rf_wdata = stage_q.ex_result;
  end

  assign bus.mem_to_wb_bus = {stage_q.hi_we, stage_q.hi_wdata,
                              stage_q.lo_we, stage_q.lo_wdata,
                              stage_q.pc,
                              stage_q.rf_we, stage_q.rf_waddr, rf_wdata};

  assign bus.mem_to_id_bus = {stage_q.hi_we, stage_q.hi_wdata,
                              stage_q.lo_we, stage_q.lo_wdata,
                              stage_q.rf_we, stage_q.rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed load/stall/bubble/forwarding cases
// plus a short run of random aligned loads.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus_if ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  localparam logic [5:0] ST_NONE   = 6'b000000;
  localparam logic [5:0] ST_BOTH   = 6'b011000;
  localparam logic [5:0] ST_BUBBLE = 6'b001000;

  localparam logic [3:0] K_B  = 4'b0010;
  localparam logic [3:0] K_BU = 4'b0001;
  localparam logic [3:0] K_H  = 4'b1000;
  localparam logic [3:0] K_HU = 4'b0100;
  localparam logic [3:0] K_W  = 4'b0000;

  int checks   = 0;
  int failures = 0;

  logic [135:0] exp_wb_q[$];
  string        exp_tag_q[$];

  logic [211:0] junk_bus, alu_bus;
  logic [31:0]  pend_rdata;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [211:0] mk(
    input logic [3:0] kind, input logic hi_we, input logic [31:0] hi_wd,
    input logic lo_we, input logic [31:0] lo_wd,
    input logic r_lo, input logic [31:0] r_lo_d,
    input logic r_hi, input logic [31:0] r_hi_d,
    input logic [31:0] pc, input logic en, input logic [3:0] wen,
    input logic sel, input logic we, input logic [4:0] waddr, input logic [31:0] res);
    return {kind, hi_we, hi_wd, lo_we, lo_wd, r_lo, r_lo_d, r_hi, r_hi_d,
            pc, en, wen, sel, we, waddr, res};
  endfunction

  function automatic logic [211:0] ld(input logic [3:0] kind, input logic [31:0] pc,
                                      input logic [4:0] waddr, input logic [31:0] addr);
    return mk(kind, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
              pc, 1'b1, 4'b0000, 1'b1, 1'b1, waddr, addr);
  endfunction

  function automatic logic [135:0] mk_wb(
    input logic hi_we, input logic [31:0] hi_wd, input logic lo_we, input logic [31:0] lo_wd,
    input logic [31:0] pc, input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    return {hi_we, hi_wd, lo_we, lo_wd, pc, we, waddr, wdata};
  endfunction

  function automatic logic [31:0] ref_align(input logic [31:0] word, input logic [1:0] a,
                                            input logic [3:0] kind);
    logic [31:0] t;
    case (kind)
      K_B:  begin t = word >> (8 * a);     return {{24{t[7]}}, t[7:0]};   end
      K_BU: begin t = word >> (8 * a);     return {24'd0, t[7:0]};        end
      K_H:  begin t = word >> (16 * a[1]); return {{16{t[15]}}, t[15:0]}; end
      K_HU: begin t = word >> (16 * a[1]); return {16'd0, t[15:0]};       end
      default: return word;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [211:0] b, input logic [5:0] st);
    bus_if.ex_to_mem_bus = b;
    bus_if.stall         = st;
  endtask

  task automatic push(input string tag, input logic [135:0] wb);
    exp_wb_q.push_back(wb);
    exp_tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [135:0] wb;
    logic [103:0] id;
    string        tag;
    #1;
    if (exp_wb_q.size() == 0) begin
      check_eq("sb_underflow", 136'(exp_wb_q.size()), 136'd1);
    end else begin
      wb  = exp_wb_q.pop_front();
      tag = exp_tag_q.pop_front();
      id  = {wb[135:70], wb[37:0]};
      check_eq({tag, "_wb"}, bus_if.mem_to_wb_bus, wb);
      check_eq({tag, "_id"}, 136'(bus_if.mem_to_id_bus), 136'(id));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  kind;
    logic [1:0]  a;
    logic [31:0] rd;
    logic [31:0] addr;

    junk_bus = mk(K_W, 1'b1, 32'hCAFE_0001, 1'b1, 32'h1, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001,
                  32'h0000_0900, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd31, 32'h9999_9999);
    alu_bus  = mk(K_W, 1'b1, 32'h1111_0000, 1'b1, 32'h2222_0000, 1'b0, 32'h0, 1'b0, 32'h0,
                  32'h0000_0200, 1'b0, 4'b0000, 1'b0, 1'b1, 5'd9, 32'h1234_5678);

    // Reset with busy inputs: everything must read zero.
    rst = 1'b0;
    drive(junk_bus, ST_NONE);
    bus_if.data_sram_rdata = 32'hFFFF_FFFF;
    #12;
    check_eq("rst_wb", bus_if.mem_to_wb_bus, 136'd0);
    check_eq("rst_id", 136'(bus_if.mem_to_id_bus), 136'd0);
    @(negedge clk);
    rst = 1'b1;
    drive('0, ST_NONE);

    // lb, lhu, lh, lw back to back.
    tick();
    drive(ld(K_B, 32'h100, 5'd5, 32'h1003), ST_NONE);
    push("lb", mk_wb(0, 0, 0, 0, 32'h100, 1, 5'd5, 32'hFFFF_FF80));
    tick();
    bus_if.data_sram_rdata = 32'h80FF_1234;
    drive(ld(K_HU, 32'h104, 5'd6, 32'h2002), ST_NONE);
    push("lhu", mk_wb(0, 0, 0, 0, 32'h104, 1, 5'd6, 32'h0000_BEEF));
    pop_check();
    tick();
    bus_if.data_sram_rdata = 32'hBEEF_0001;
    drive(ld(K_H, 32'h108, 5'd7, 32'h2002), ST_NONE);
    push("lh", mk_wb(0, 0, 0, 0, 32'h108, 1, 5'd7, 32'hFFFF_BEEF));
    pop_check();
    tick();
    bus_if.data_sram_rdata = 32'hBEEF_0001;
    drive(ld(K_W, 32'h10C, 5'd8, 32'h3000), ST_NONE);
    push("lw_fresh", mk_wb(0, 0, 0, 0, 32'h10C, 1, 5'd8, 32'h1122_3344));
    pop_check();

    // lw held across a 3-cycle full stall while the SRAM word changes.
    tick();
    bus_if.data_sram_rdata = 32'h1122_3344;
    drive(junk_bus, ST_BOTH);
    push("lw_held", mk_wb(0, 0, 0, 0, 32'h10C, 1, 5'd8, 32'h1122_3344));
    pop_check();
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_if.data_sram_rdata = 32'hDEAD_BEEF;
      if (i < 2) begin
        drive(junk_bus, ST_BOTH);
        push("lw_held", mk_wb(0, 0, 0, 0, 32'h10C, 1, 5'd8, 32'h1122_3344));
      end else begin
        drive(alu_bus, ST_NONE);
        push("alu", mk_wb(1, 32'h1111_0000, 1, 32'h2222_0000, 32'h200, 1, 5'd9, 32'h1234_5678));
      end
      pop_check();
    end

    // Bubble, then mfhi / mflo / priority / store.
    tick();
    drive(alu_bus, ST_BUBBLE);
    push("bubble", 136'd0);
    pop_check();
    tick();
    drive(mk(K_W, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001, 32'h300, 0, 4'b0000, 0, 1, 5'd10, 32'h55),
          ST_NONE);
    push("mfhi", mk_wb(0, 0, 0, 0, 32'h300, 1, 5'd10, 32'hCAFE_0001));
    pop_check();
    tick();
    drive(mk(K_W, 0, 0, 0, 0, 1, 32'h0BEE_0002, 0, 0, 32'h304, 0, 4'b0000, 0, 1, 5'd11, 32'h66),
          ST_NONE);
    push("mflo", mk_wb(0, 0, 0, 0, 32'h304, 1, 5'd11, 32'h0BEE_0002));
    pop_check();
    tick();
    drive(mk(K_W, 0, 0, 0, 0, 1, 32'h0BEE_0002, 1, 32'hCAFE_0003, 32'h308, 0, 4'b0000, 0, 1,
             5'd12, 32'h77), ST_NONE);
    push("hi_over_lo", mk_wb(0, 0, 0, 0, 32'h308, 1, 5'd12, 32'hCAFE_0003));
    pop_check();
    tick();
    drive(mk(K_W, 0, 0, 0, 0, 0, 0, 0, 0, 32'h30C, 1, 4'b1111, 0, 0, 5'd0, 32'h4000),
          ST_NONE);
    push("store", mk_wb(0, 0, 0, 0, 32'h30C, 0, 5'd0, 32'h4000));
    pop_check();

    // Random loads, each with its own SRAM word one cycle later.
    pend_rdata = $urandom;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus_if.data_sram_rdata = pend_rdata;
      case ($urandom_range(4))
        0: kind = K_B;
        1: kind = K_BU;
        2: kind = K_H;
        3: kind = K_HU;
        default: kind = K_W;
      endcase
      a    = 2'($urandom_range(3));
      addr = {28'h000_0100, 2'b00, a};
      rd   = $urandom;
      drive(ld(kind, 32'h400 + 32'(i * 4), 5'(i + 1), addr), ST_NONE);
      push("rnd_ld", mk_wb(0, 0, 0, 0, 32'h400 + 32'(i * 4), 1, 5'(i + 1),
                           ref_align(rd, a, kind)));
      pend_rdata = rd;
      pop_check();
    end
    tick();
    bus_if.data_sram_rdata = pend_rdata;
    drive('0, ST_NONE);
    push("nop", 136'd0);
    pop_check();

    // Reset while a load sits in HELD.
    tick();
    drive(ld(K_W, 32'h500, 5'd12, 32'h20), ST_NONE);
    push("lw2_fresh", mk_wb(0, 0, 0, 0, 32'h500, 1, 5'd12, 32'hAAAA_5555));
    pop_check();
    tick();
    bus_if.data_sram_rdata = 32'hAAAA_5555;
    drive(junk_bus, ST_BOTH);
    push("lw2_held", mk_wb(0, 0, 0, 0, 32'h500, 1, 5'd12, 32'hAAAA_5555));
    pop_check();
    tick();
    bus_if.data_sram_rdata = 32'h7777_7777;
    drive(junk_bus, ST_BOTH);
    pop_check();
    #2;
    rst = 1'b0;
    #1;
    check_eq("rst_held_wb", bus_if.mem_to_wb_bus, 136'd0);
    check_eq("rst_held_id", 136'(bus_if.mem_to_id_bus), 136'd0);
    exp_wb_q.delete();
    exp_tag_q.delete();
    tick();
    check_eq("rst_edge_wb", bus_if.mem_to_wb_bus, 136'd0);
    rst = 1'b1;
    drive(ld(K_W, 32'h600, 5'd13, 32'h40), ST_NONE);
    push("lw3_fresh", mk_wb(0, 0, 0, 0, 32'h600, 1, 5'd13, 32'h0BAD_F00D));
    tick();
    bus_if.data_sram_rdata = 32'h0BAD_F00D;
    drive('0, ST_NONE);
    push("nop_end", 136'd0);
    pop_check();
    tick();
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
